instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage of the CPU pipeline. Drives a synchronous instruction memory from a program counter and loads the 32-bit `if_id_reg` consumed by decode. It honours the pipeline `stall` without losing or duplicating words, using a one-entry skid buffer for the word already in flight. When the program is exhausted it drains and then feeds no-op bubbles (`32'd0`).

## Interface
- `ADDR_WIDTH`, default 8: instruction memory address width.
- `PROGRAM_LENGTH`, default 256: number of valid words, addresses `0..PROGRAM_LENGTH-1`. Must be ≤ 2^ADDR_WIDTH.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  start/restart pulse, sampled in IDLE or DONE only.
- `stall`  in  1  hold request from the hazard logic; the same signal decode sees.
- `imem_addr`  out  ADDR_WIDTH  read address. Combinational, equals `pc`.
- `imem_rdata`  in  32  memory data, valid the cycle after the address is sampled (1-cycle read latency).
- `if_id_reg`  out  32  instruction presented to decode; `32'd0` is a no-op.
- `if_pc`  out  ADDR_WIDTH  address of the word currently in `if_id_reg`.
- `program_done`  out  1  high in DONE.
- `fetch_count`  out  32  number of words loaded into `if_id_reg` since the last start. Saturates at `32'hFFFF_FFFF`.

## Operation
- **Reset values:** state IDLE; `pc`, `if_pc` = 0; `if_id_reg` = 0; `inflight`, `skid_valid`, `program_done` = 0; `fetch_count` = 0. Any in-flight or skid data is discarded, including on reset mid-program.
- **States:**
  - IDLE → FETCH on `run`.
  - FETCH → DRAIN when an issue occurs at `pc == PROGRAM_LENGTH-1`.
  - DRAIN → DONE on the edge where the last word enters `if_id_reg`, i.e. the load leaves `inflight` = 0 and `skid_valid` = 0.
  - DONE → FETCH on `run`.
  - Entering FETCH always clears `pc` and `fetch_count` to 0.
- **Issue:** `issue = (state == FETCH) && !stall`. On issue, `pc <= pc + 1` and `inflight <= 1`; otherwise `inflight <= 0`. When `pc` reaches `PROGRAM_LENGTH` it is held there and no address beyond it is issued.
- **Load of `if_id_reg`, not stalled:**
  - If `skid_valid`: load the skid word and clear `skid_valid`.
  - Else if `inflight`: load `imem_rdata`.
  - Else: load `32'd0`.
  - `if_pc` moves with the data. `fetch_count` increments only on a real word, never on a bubble.
- **Load of `if_id_reg`, stalled:**
  - `if_id_reg` and `if_pc` hold.
  - If `inflight`: capture `imem_rdata` and its address into the skid buffer and set `skid_valid`.
- **Skid capacity:** one entry is sufficient. No issue happens while stalled, so at most one word is in flight when a stall begins. A skid drain and a new issue in the same cycle are legal; order is preserved.
- **Run handling:** `run` in FETCH or DRAIN is ignored. `stall` in IDLE or DONE holds `if_id_reg`.

## Timing
- `run` sampled at edge E0 → FETCH; `imem_addr` = 0 in the following cycle.
- Edge E1 → `inflight` = 1, `pc` = 1.
- Edge E2 → `if_id_reg` = word0. Start-to-first-instruction latency is 2 edges.
- Steady throughput: one word per cycle while `stall` is low.
- **Stall of N cycles:**
  - `if_id_reg` is frozen for N cycles.
  - The first edge after `stall` falls loads the skid word (or the in-flight word); the next sequential word follows one cycle later.
  - No word is skipped or repeated.
- **Program end:** `program_done` rises on the same edge that loads the final word. With no stall that is 2 edges after the last issue. A stall during DRAIN postpones it by the stall length.

## Test plan
- **Basic run:** PROGRAM_LENGTH=4, memory words 0x1111_0000..0x1111_0003, `run` pulse, no stall.
  - `if_id_reg` shows the four words on consecutive cycles starting 2 edges after `run`.
  - Then `32'd0` continuously; `program_done` = 1; `fetch_count` = 4.
- **Single-cycle stall:** assert `stall` for 1 cycle while word1 is in `if_id_reg` and word2 is in flight.
  - `if_id_reg` = word1 for 2 cycles, then word2, word3.
  - `fetch_count` ends at 4; `if_pc` sequence is 0, 1, 1, 2, 3.
- **Long stall:** stall for 5 cycles mid-program.
  - No memory address advances during the stall.
  - Skid holds exactly one word; output order is unchanged.
- **Stall at end:** stall asserted on the edge the final word would load.
  - `program_done` stays 0 until the stall is released.
  - The final word then loads, and `program_done` = 1 on that same edge.
- **Reset mid-program:** `reset` while `skid_valid` = 1.
  - Next cycle: all outputs = 0 and state IDLE.
  - A following `run` restarts from address 0 with no stale word.
- **Restart and run filtering:**
  - `run` in DONE: the program replays from address 0 and `fetch_count` restarts at 0.
  - `run` pulsed during FETCH: no effect on `pc`.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and the IF/ID outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  run;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rdata;
  logic [31:0]           if_id_reg;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  program_done;
  logic [31:0]           fetch_count;

  modport master (
    input  run, stall, imem_rdata,
    output imem_addr, if_id_reg, if_pc, program_done, fetch_count
  );

  modport slave (
    output run, stall, imem_rdata,
    input  imem_addr, if_id_reg, if_pc, program_done, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a 1-cycle-latency instruction memory from the PC,
// absorbs stalls with a one-entry skid buffer and feeds bubbles once the program ends.
module instr_fetch #(
  parameter int ADDR_WIDTH     = 8,
  parameter int PROGRAM_LENGTH = 256
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);
  // One extra PC bit so the PC can rest at PROGRAM_LENGTH even when it equals 2^ADDR_WIDTH.
  localparam int              PC_W    = ADDR_WIDTH + 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROGRAM_LENGTH - 1);
  localparam logic [PC_W-1:0] PC_END  = PC_W'(PROGRAM_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [31:0]           skid_data_q, skid_data_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]           if_id_q, if_id_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic                  issue;
  logic                  load_word;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    if_id_d       = if_id_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;
    load_word     = 1'b0;
    issue         = (state_q == S_FETCH) && !bus.stall && (pc_q != PC_END);

    // The skid word is always older than the in-flight word, so it drains first.
    if (!bus.stall) begin
      if (skid_valid_q) begin
        if_id_d      = skid_data_q;
        if_pc_d      = skid_pc_q;
        skid_valid_d = 1'b0;
        load_word    = 1'b1;
      end else if (inflight_q) begin
        if_id_d   = bus.imem_rdata;
        if_pc_d   = inflight_pc_q;
        load_word = 1'b1;
      end else begin
        if_id_d = '0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = bus.imem_rdata;
      skid_pc_d    = inflight_pc_q;
    end

    if (load_word && (fetch_count_q != '1)) fetch_count_d = fetch_count_q + 32'd1;

    if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q[ADDR_WIDTH-1:0];
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.run) begin
          state_d       = S_FETCH;
          pc_d          = '0;
          fetch_count_d = '0;
        end
      end
      S_FETCH: if (issue && (pc_q == PC_LAST)) state_d = S_DRAIN;
      S_DRAIN: if (load_word && !inflight_d && !skid_valid_d) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      if_id_q       <= '0;
      if_pc_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      skid_valid_q  <= skid_valid_d;
      if_id_q       <= if_id_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Payload registers are qualified by inflight_q / skid_valid_q and need no reset.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    skid_data_q   <= skid_data_d;
    skid_pc_q     <= skid_pc_d;
  end

  assign bus.imem_addr    = pc_q[ADDR_WIDTH-1:0];
  assign bus.if_id_reg    = if_id_q;
  assign bus.if_pc        = if_pc_q;
  assign bus.program_done = (state_q == S_DONE);
  assign bus.fetch_count  = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random run/stall/reset traffic,
// checked every cycle against a queue-based model of issued-but-not-delivered words.
module tb_instr_fetch;
  localparam int AW = 2;
  localparam int PL = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_fetch_if #(.ADDR_WIDTH(AW)) ifc ();

  instr_fetch #(.ADDR_WIDTH(AW), .PROGRAM_LENGTH(PL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [PL];
  always @(posedge clk) ifc.imem_rdata <= mem[ifc.imem_addr];

  int total = 0;
  int bad   = 0;

  // Model: addresses issued but not yet delivered, in program order.
  int          m_q[$];
  int          m_next;
  bit          m_started;
  logic [31:0] m_if;
  logic [31:0] m_cnt;
  int          m_pc;
  bit          m_pc_known;
  bit          m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit rn, input bit st);
    bit running;
    if (r) begin
      m_q.delete();
      m_started  = 1'b0;
      m_next     = 0;
      m_cnt      = '0;
      m_if       = '0;
      m_pc       = 0;
      m_pc_known = 1'b1;
    end else begin
      running = m_started && !((m_next == PL) && (m_q.size() == 0));
      if (!st) begin
        if (m_q.size() > 0) begin
          m_if       = mem[m_q[0]];
          m_pc       = m_q[0];
          m_pc_known = 1'b1;
          void'(m_q.pop_front());
          m_cnt      = m_cnt + 32'd1;
        end else begin
          m_if       = '0;
          m_pc_known = 1'b0;
        end
      end
      if (!running && rn) begin
        m_started = 1'b1;
        m_next    = 0;
        m_cnt     = '0;
      end else if (running && !st && (m_next < PL)) begin
        m_q.push_back(m_next);
        m_next++;
      end
    end
    m_done = m_started && (m_next == PL) && (m_q.size() == 0);
  endtask

  task automatic step(input bit r, input bit rn, input bit st);
    @(negedge clk);
    reset     = r;
    ifc.run   = rn;
    ifc.stall = st;
    @(posedge clk);
    model_edge(r, rn, st);
    #1;
    chk("if_id_reg", ifc.if_id_reg, m_if);
    chk("fetch_count", ifc.fetch_count, m_cnt);
    chk("program_done", 32'(ifc.program_done), 32'(m_done));
    if (m_next < PL) chk("imem_addr", 32'(ifc.imem_addr), 32'(m_next));
    if (m_pc_known) chk("if_pc", 32'(ifc.if_pc), 32'(m_pc));
  endtask

  task automatic run_steps(input int n, input bit st);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, st);
  endtask

  initial begin
    int exp_pcs[5];
    exp_pcs = '{0, 1, 1, 2, 3};
    ifc.run   = 1'b0;
    ifc.stall = 1'b0;
    for (int i = 0; i < PL; i++) mem[i] = 32'h1111_0000 + 32'(i);

    // Reset and idle, including a stall while idle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_if_id", ifc.if_id_reg, 32'd0);
    chk("reset_done", 32'(ifc.program_done), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    run_steps(2, 1'b0);

    // Basic run: first word two edges after run.
    step(1'b0, 1'b1, 1'b0);
    chk("basic_addr0", 32'(ifc.imem_addr), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("basic_word0", ifc.if_id_reg, 32'h1111_0000);
    run_steps(6, 1'b0);
    chk("basic_count", ifc.fetch_count, 32'd4);
    chk("basic_done", 32'(ifc.program_done), 32'd1);
    chk("basic_bubble", ifc.if_id_reg, 32'd0);

    // Single-cycle stall while word1 is presented and word2 is in flight.
    step(1'b0, 1'b1, 1'b0);
    chk("restart_count", ifc.fetch_count, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, i == 2);
      chk("stall1_if_pc", 32'(ifc.if_pc), 32'(exp_pcs[i]));
      chk("stall1_word", ifc.if_id_reg, 32'h1111_0000 + 32'(exp_pcs[i]));
    end
    run_steps(2, 1'b0);
    chk("stall1_count", ifc.fetch_count, 32'd4);

    // Long stall mid-program.
    step(1'b0, 1'b1, 1'b0);
    run_steps(3, 1'b0);
    run_steps(5, 1'b1);
    run_steps(6, 1'b0);

    // Stall on the edge the final word would load.
    step(1'b0, 1'b1, 1'b0);
    run_steps(4, 1'b0);
    run_steps(3, 1'b1);
    chk("end_stall_done", 32'(ifc.program_done), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("end_release_done", 32'(ifc.program_done), 32'd1);
    chk("end_release_word", ifc.if_id_reg, 32'h1111_0003);

    // Reset while a word sits in the skid buffer.
    step(1'b0, 1'b1, 1'b0);
    run_steps(3, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_mid_if_id", ifc.if_id_reg, 32'd0);
    chk("rst_mid_if_pc", 32'(ifc.if_pc), 32'd0);
    chk("rst_mid_count", ifc.fetch_count, 32'd0);
    chk("rst_mid_addr", 32'(ifc.imem_addr), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_mid_word0", ifc.if_id_reg, 32'h1111_0000);
    run_steps(5, 1'b0);

    // Run pulsed during FETCH must not disturb the PC.
    step(1'b0, 1'b1, 1'b0);
    run_steps(2, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("run_filter_addr", 32'(ifc.imem_addr), 32'd3);
    run_steps(5, 1'b0);

    // Random traffic over fresh memory contents.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < PL; i++) mem[i] = $urandom;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
